// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle fp_div among NUM_REQ requesters.
// One division in flight at a time; results return tagged with the requester ID.
module fp_div_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int FP_WIDTH  = 32,
  parameter int RES_WIDTH = 38,
  parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*FP_WIDTH-1:0]  req_a_i,
  input  logic [NUM_REQ*FP_WIDTH-1:0]  req_b_i,
  input  logic [NUM_REQ*3-1:0]         req_rnd_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [ID_WIDTH-1:0]          rsp_id_o,
  output logic [RES_WIDTH-1:0]         rsp_result_o,
  output logic [2:0]                   rsp_rnd_o,
  output logic                         rsp_dz_o,
  output logic                         div_start_o,
  output logic [FP_WIDTH-1:0]          div_a_o,
  output logic [FP_WIDTH-1:0]          div_b_o,
  output logic [2:0]                   div_rnd_o,
  input  logic                         div_done_i,
  input  logic [RES_WIDTH-1:0]         div_result_i,
  input  logic                         div_dz_i,
  output logic                         busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                 state_q, state_d;
  logic [ID_WIDTH-1:0]    rr_q, rr_d, id_q, id_d, win;
  logic [FP_WIDTH-1:0]    a_q, a_d, b_q, b_d, a_sel, b_sel;
  logic [2:0]             rnd_q, rnd_d, rnd_sel;
  logic [RES_WIDTH-1:0]   res_q, res_d;
  logic                   dz_q, dz_d;
  logic                   any_vld;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_WIDTH:0]      idx, nxt;

  // Search upward from the RR pointer; one extra bit keeps rr+i from overflowing before the wrap.
  always_comb begin
    any_vld = 1'b0;
    win     = '0;
    grant   = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_q} + (ID_WIDTH+1)'(i);
      if (idx >= (ID_WIDTH+1)'(NUM_REQ)) idx = idx - (ID_WIDTH+1)'(NUM_REQ);
      if (!any_vld && req_valid_i[idx[ID_WIDTH-1:0]]) begin
        any_vld = 1'b1;
        win     = idx[ID_WIDTH-1:0];
      end
    end
    grant[win] = any_vld;
  end

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    rnd_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == ID_WIDTH'(k)) begin
        a_sel   = req_a_i[k*FP_WIDTH +: FP_WIDTH];
        b_sel   = req_b_i[k*FP_WIDTH +: FP_WIDTH];
        rnd_sel = req_rnd_i[k*3 +: 3];
      end
    end
    nxt = {1'b0, win} + (ID_WIDTH+1)'(1);
    if (nxt >= (ID_WIDTH+1)'(NUM_REQ)) nxt = '0;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    rnd_d   = rnd_q;
    res_d   = res_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (any_vld) begin
        a_d     = a_sel;
        b_d     = b_sel;
        rnd_d   = rnd_sel;
        id_d    = win;
        rr_d    = nxt[ID_WIDTH-1:0];
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (div_done_i) begin
        res_d   = div_result_i;
        dz_d    = div_dz_i;
        state_d = RESP;
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rnd_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rnd_q   <= rnd_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  // Grants are masked while reset is held so no requester sees an accept it cannot get.
  assign req_ready_o  = (state_q == IDLE && reset_i) ? grant : '0;
  assign div_start_o  = (state_q == ISSUE);
  assign rsp_valid_o  = (state_q == RESP);
  assign busy_o       = (state_q != IDLE);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = res_q;
  assign rsp_rnd_o    = rnd_q;
  assign rsp_dz_o     = dz_q;
  assign div_a_o      = a_q;
  assign div_b_o      = b_q;
  assign div_rnd_o    = rnd_q;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter: a 4-requester and a 3-requester instance,
// each driven by a behavioural divider stub with programmable latency.
module tb_fp_div_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [37:0] stub_res(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return {a[31], 8'hFF, 23'h0, 6'h0};
    if (a == 32'h40C00000 && b == 32'h40000000) return {32'h40400000, 6'h0};
    return {a + b, 6'h15};
  endfunction

  // ---------------- 4-requester instance ----------------
  logic [3:0]    vld4 = '0, rdy4;
  logic [127:0]  a4 = '0, b4 = '0;
  logic [11:0]   rnd4 = '0;
  logic          rsp_valid4, rsp_ready4 = 1'b0, rsp_dz4;
  logic [1:0]    rsp_id4;
  logic [37:0]   rsp_res4, res4;
  logic [2:0]    rsp_rnd4, div_rnd4;
  logic          div_start4, done4, dz4, busy4, force4 = 1'b0;
  logic [31:0]   div_a4, div_b4;
  logic [7:0]    cnt4 = '0;
  int            lat4 = 3;

  fp_div_arbiter #(.NUM_REQ(4), .FP_WIDTH(32), .RES_WIDTH(38)) u_dut4 (
    .clk_i(clk), .reset_i(rst_n),
    .req_valid_i(vld4), .req_ready_o(rdy4),
    .req_a_i(a4), .req_b_i(b4), .req_rnd_i(rnd4),
    .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready4),
    .rsp_id_o(rsp_id4), .rsp_result_o(rsp_res4), .rsp_rnd_o(rsp_rnd4), .rsp_dz_o(rsp_dz4),
    .div_start_o(div_start4), .div_a_o(div_a4), .div_b_o(div_b4), .div_rnd_o(div_rnd4),
    .div_done_i(done4), .div_result_i(res4), .div_dz_i(dz4),
    .busy_o(busy4)
  );

  always @(posedge clk) begin
    if (div_start4) cnt4 <= lat4[7:0];
    else if (cnt4 != 0) cnt4 <= cnt4 - 8'd1;
  end
  assign done4 = (cnt4 == 8'd1) | force4;
  assign res4  = done4 ? stub_res(div_a4, div_b4) : '0;
  assign dz4   = done4 && (div_b4 == 32'h0);

  // ---------------- 3-requester instance ----------------
  logic [2:0]    vld3 = '0, rdy3;
  logic [95:0]   a3 = '0, b3 = '0;
  logic [8:0]    rnd3 = '0;
  logic          rsp_valid3, rsp_ready3 = 1'b0, rsp_dz3;
  logic [1:0]    rsp_id3;
  logic [37:0]   rsp_res3, res3;
  logic [2:0]    rsp_rnd3, div_rnd3;
  logic          div_start3, done3, dz3, busy3;
  logic [31:0]   div_a3, div_b3;
  logic [7:0]    cnt3 = '0;
  int            lat3 = 1;

  fp_div_arbiter #(.NUM_REQ(3), .FP_WIDTH(32), .RES_WIDTH(38)) u_dut3 (
    .clk_i(clk), .reset_i(rst_n),
    .req_valid_i(vld3), .req_ready_o(rdy3),
    .req_a_i(a3), .req_b_i(b3), .req_rnd_i(rnd3),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3),
    .rsp_id_o(rsp_id3), .rsp_result_o(rsp_res3), .rsp_rnd_o(rsp_rnd3), .rsp_dz_o(rsp_dz3),
    .div_start_o(div_start3), .div_a_o(div_a3), .div_b_o(div_b3), .div_rnd_o(div_rnd3),
    .div_done_i(done3), .div_result_i(res3), .div_dz_i(dz3),
    .busy_o(busy3)
  );

  always @(posedge clk) begin
    if (div_start3) cnt3 <= lat3[7:0];
    else if (cnt3 != 0) cnt3 <= cnt3 - 8'd1;
  end
  assign done3 = (cnt3 == 8'd1);
  assign res3  = done3 ? stub_res(div_a3, div_b3) : '0;
  assign dz3   = done3 && (div_b3 == 32'h0);

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    vld4 = 4'hF;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdy4 !== 4'h0) begin errors++; $display("FAIL reset_ready: got %b want 0000", rdy4); end
    checks++; if ({rsp_valid4, busy4, div_start4, rsp_dz4} !== 4'b0) begin errors++;
      $display("FAIL reset_flags: got v%b b%b s%b dz%b want all 0", rsp_valid4, busy4, div_start4, rsp_dz4); end
    checks++; if ({rsp_id4, rsp_res4, rsp_rnd4, div_a4, div_b4, div_rnd4} !== '0) begin errors++;
      $display("FAIL reset_data: id %0d res %h a %h b %h not all zero", rsp_id4, rsp_res4, div_a4, div_b4); end
    vld4 = 4'h0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n, starts;
    lat4 = 3;
    a4[64 +: 32] = 32'h40C00000;
    b4[64 +: 32] = 32'h40000000;
    rnd4[6 +: 3] = 3'd0;
    @(posedge clk); #1;
    vld4 = 4'b0100;
    #1;
    checks++; if (rdy4 !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", rdy4); end
    @(posedge clk); #1;
    vld4 = 4'b0000;
    checks++; if (div_start4 !== 1'b1 || div_a4 !== 32'h40C00000 || div_b4 !== 32'h40000000) begin errors++;
      $display("FAIL single_issue: start %b a %h b %h want 1 40c00000 40000000", div_start4, div_a4, div_b4); end
    n = 1; starts = div_start4 ? 1 : 0;
    while (!rsp_valid4 && n < 60) begin
      @(posedge clk); #1; n++;
      if (div_start4) starts++;
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL single_latency: got %0d want 5", n); end
    checks++; if (starts !== 1) begin errors++; $display("FAIL single_starts: got %0d want 1", starts); end
    checks++; if (rsp_id4 !== 2'd2 || rsp_dz4 !== 1'b0 || rsp_res4[37:6] !== 32'h40400000 || rsp_rnd4 !== 3'd0) begin errors++;
      $display("FAIL single_rsp: id %0d dz %b res %h want 2 0 40400000", rsp_id4, rsp_dz4, rsp_res4[37:6]); end
    rsp_ready4 = 1'b1;
    @(posedge clk); #1;
    rsp_ready4 = 1'b0;
    checks++; if (rsp_valid4 !== 1'b0 || busy4 !== 1'b0) begin errors++;
      $display("FAIL single_done: valid %b busy %b want 0 0", rsp_valid4, busy4); end
  endtask

  task automatic test_round_robin();
    logic [1:0] ids [6];
    logic [1:0] exp_ids [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int got = 0, n = 0;
    do_reset();
    lat4 = 2;
    rsp_ready4 = 1'b1;
    vld4 = 4'hF;
    while (got < 6 && n < 200) begin
      #1;
      if (rdy4 !== 4'h0) begin
        checks++; if ($countones(rdy4) != 1) begin errors++; $display("FAIL rr_onehot: got %b want one bit", rdy4); end
      end
      if (rsp_valid4) begin ids[got] = rsp_id4; got++; end
      if (got == 6) vld4 = 4'h0;
      @(posedge clk); n++;
    end
    checks++; if (got !== 6) begin errors++; $display("FAIL rr_timeout: got %0d responses want 6", got); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (ids[i] !== exp_ids[i]) begin errors++; $display("FAIL rr_seq[%0d]: got %0d want %0d", i, ids[i], exp_ids[i]); end
    end
    n = 0;
    while (busy4 && n < 50) begin @(posedge clk); #1; n++; end
    rsp_ready4 = 1'b0;
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    lat4 = 4;
    rsp_ready4 = 1'b0;
    a4[0 +: 32] = 32'h11111111; b4[0 +: 32] = 32'h22222222;
    a4[32 +: 32] = 32'h01010101; b4[32 +: 32] = 32'h02020202;
    vld4 = 4'b0011;
    @(posedge clk); #1;
    vld4 = 4'b0010;
    while (!rsp_valid4 && n < 60) begin @(posedge clk); #1; n++; end
    checks++; if (!rsp_valid4) begin errors++; $display("FAIL bp_timeout: rsp_valid %b want 1", rsp_valid4); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid4 !== 1'b1 || rsp_id4 !== 2'd0 || rsp_res4 !== {32'h33333333, 6'h15} || rdy4 !== 4'h0 || div_start4 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v %b id %0d res %h rdy %b st %b want 1 0 %h 0000 0",
                 i, rsp_valid4, rsp_id4, rsp_res4, rdy4, div_start4, {32'h33333333, 6'h15});
      end
    end
    rsp_ready4 = 1'b1;
    @(posedge clk); #1;
    rsp_ready4 = 1'b0;
    checks++; if (rsp_valid4 !== 1'b0 || rdy4 !== 4'b0010) begin errors++;
      $display("FAIL bp_next_grant: v %b rdy %b want 0 0010", rsp_valid4, rdy4); end
    @(posedge clk); #1;
    vld4 = 4'h0;
    checks++; if (div_start4 !== 1'b1 || div_a4 !== 32'h01010101) begin errors++;
      $display("FAIL bp_next_issue: start %b a %h want 1 01010101", div_start4, div_a4); end
    rsp_ready4 = 1'b1;
    n = 0;
    while (busy4 && n < 60) begin @(posedge clk); #1; n++; end
    rsp_ready4 = 1'b0;
  endtask

  task automatic test_div_zero();
    int n = 0;
    lat4 = 5;
    a4[32 +: 32] = 32'h3F800000; b4[32 +: 32] = 32'h00000000;
    rnd4[3 +: 3] = 3'b011;
    vld4 = 4'b0010;
    @(posedge clk); #1;
    vld4 = 4'h0;
    while (!rsp_valid4 && n < 60) begin @(posedge clk); #1; n++; end
    checks++; if (rsp_dz4 !== 1'b1 || rsp_res4[37:6] !== 32'h7F800000) begin errors++;
      $display("FAIL dz_rsp: dz %b res %h want 1 7f800000", rsp_dz4, rsp_res4[37:6]); end
    checks++; if (rsp_id4 !== 2'd1 || rsp_rnd4 !== 3'b011) begin errors++;
      $display("FAIL dz_tag: id %0d rnd %b want 1 011", rsp_id4, rsp_rnd4); end
    rsp_ready4 = 1'b1;
    n = 0;
    while (busy4 && n < 20) begin @(posedge clk); #1; n++; end
    rsp_ready4 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    lat4 = 20;
    vld4 = 4'b1000;
    while (!div_start4 && n < 20) begin @(posedge clk); #1; n++; end
    vld4 = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy4 !== 1'b1 || rsp_valid4 !== 1'b0) begin errors++;
      $display("FAIL mid_wait: busy %b v %b want 1 0", busy4, rsp_valid4); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    force4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid4 !== 1'b0 || busy4 !== 1'b0) begin errors++;
        $display("FAIL mid_ignore[%0d]: v %b busy %b want 0 0", i, rsp_valid4, busy4); end
    end
    force4 = 1'b0;
    vld4 = 4'hF;
    #1;
    checks++; if (rdy4 !== 4'b0001) begin errors++; $display("FAIL mid_rr_ptr: got %b want 0001", rdy4); end
    vld4 = 4'h0;
  endtask

  task automatic test_nonpow2();
    logic [1:0] ids [4];
    logic [1:0] exp_ids [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    int got = 0, n = 0;
    do_reset();
    lat3 = 1;
    rsp_ready3 = 1'b1;
    vld3 = 3'b111;
    while (got < 4 && n < 200) begin
      #1;
      if (rsp_valid3) begin ids[got] = rsp_id3; got++; end
      if (got == 4) vld3 = 3'b000;
      @(posedge clk); n++;
    end
    checks++; if (got !== 4) begin errors++; $display("FAIL np2_timeout: got %0d responses want 4", got); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ids[i] !== exp_ids[i]) begin errors++; $display("FAIL np2_seq[%0d]: got %0d want %0d", i, ids[i], exp_ids[i]); end
    end
    rsp_ready3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_div_zero();
    test_reset_mid();
    test_nonpow2();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
